// File: rtl/port_arbiter_2_pkg.sv
// Shared sequencer definitions: ownership state encodings, default hold
// timeout and the hand-off decision reused by the CPU's port arbiters.
package port_arbiter_2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_TW      = 8;

    // After a release the other requester wins; the owner only keeps the
    // port when it is still asking and nobody else is.
    function automatic arb_state_e hand_off(
        input logic       other_req,
        input logic       own_req,
        input arb_state_e other_s,
        input arb_state_e own_s
    );
        if (other_req) begin
            return other_s;
        end else if (own_req) begin
            return own_s;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/port_arbiter_2_if.sv
// Request/grant bundle between the two requesting units, the shared port
// and the arbiter that sequences it.
interface port_arbiter_2_if;

    logic req0;
    logic req1;
    logic port_ready;
    logic sel;
    logic port_valid;
    logic gnt0;
    logic gnt1;
    logic done0;
    logic done1;
    logic timeout_err;

    // The arbiter side drives the port qualifiers and grants.
    modport master (
        input  req0, req1, port_ready,
        output sel, port_valid, gnt0, gnt1, done0, done1, timeout_err
    );

    modport slave (
        output req0, req1, port_ready,
        input  sel, port_valid, gnt0, gnt1, done0, done1, timeout_err
    );

endinterface

// File: rtl/port_arbiter_2_hold_timer.sv
// Grant hold counter: counts owned cycles, saturates at TIMEOUT-1 and flags
// that terminal count so the arbiter can force a release.
module port_arbiter_2_hold_timer
    import port_arbiter_2_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TW      = DEFAULT_TW
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign tc = (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + TW'(1);
        end
    end

    // NOTE: the counter is reset explicitly; a stale count after an
    // asynchronous reset would cut the first grant short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/port_arbiter_2.sv
// Two-requester round-robin arbiter for one shared downstream port: drives
// the external 2:1 mux select, qualifies the port and releases on
// completion or hold timeout.
module port_arbiter_2
    import port_arbiter_2_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TW      = DEFAULT_TW
) (
    input  logic               clk,
    input  logic               rst,
    port_arbiter_2_if.master   bus
);

    if (TIMEOUT < 2 || TIMEOUT > 255 || (2 ** TW) <= TIMEOUT) begin : g_bad_params
        $error("port_arbiter_2: TIMEOUT must be 2..255 and fit in TW bits");
    end

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic       done0;
    logic       done1;
    logic       timeout_err;
    logic       owning;
    logic       released;
    logic       hold_tc;

    assign owning   = (state_q != IDLE);
    assign released = done0 || done1 || timeout_err;

    port_arbiter_2_hold_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr (!owning || released),
        .en  (owning),
        .tc  (hold_tc)
    );

    // NOTE: every signal gets a default before the case so no path through
    // this block leaves a value unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        done0       = 1'b0;
        done1       = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (bus.port_ready) begin
                    done0   = 1'b1;
                    last_d  = 1'b0;
                    state_d = hand_off(bus.req1, bus.req0, OWN1, OWN0);
                end else if (hold_tc) begin
                    // A timed-out owner must drop and re-request.
                    timeout_err = 1'b1;
                    last_d      = 1'b0;
                    state_d     = hand_off(bus.req1, 1'b0, OWN1, OWN0);
                end
            end
            OWN1: begin
                if (bus.port_ready) begin
                    done1   = 1'b1;
                    last_d  = 1'b1;
                    state_d = hand_off(bus.req0, bus.req1, OWN0, OWN1);
                end else if (hold_tc) begin
                    timeout_err = 1'b1;
                    last_d      = 1'b1;
                    state_d     = hand_off(bus.req0, 1'b0, OWN0, OWN1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Grants and the mux select come straight off the state flops.
    assign bus.gnt0        = (state_q == OWN0);
    assign bus.gnt1        = (state_q == OWN1);
    assign bus.sel         = (state_q == OWN1);
    assign bus.port_valid  = owning;
    assign bus.done0       = done0;
    assign bus.done1       = done1;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_port_arbiter_2.sv
// Directed scoreboard bench for port_arbiter_2 with a short hold timeout.
module tb_port_arbiter_2;

    typedef struct {
        logic [6:0] bits;   // {gnt0, gnt1, sel, port_valid, done0, done1, timeout_err}
        string      name;
    } exp_t;

    localparam logic [6:0] E_IDLE = 7'b0000000;
    localparam logic [6:0] E_OWN0 = 7'b1001000;
    localparam logic [6:0] E_OWN1 = 7'b0111000;
    localparam logic [6:0] D0     = 7'b0000100;
    localparam logic [6:0] D1     = 7'b0000010;
    localparam logic [6:0] TO     = 7'b0000001;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    port_arbiter_2_if bus ();

    port_arbiter_2 #(
        .TIMEOUT (4),
        .TW      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b ({g0,g1,sel,pv,d0,d1,to})", name, got, want);
        end
    endtask

    // One cycle of stimulus: drive just after the edge, queue the outputs
    // expected for the rest of that cycle.
    task automatic step(input logic r, input logic r0, input logic r1, input logic rdy,
                        input logic [6:0] want, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.req0       = r0;
        bus.req1       = r1;
        bus.port_ready = rdy;
        e.bits = want;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the DUT against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {bus.gnt0, bus.gnt1, bus.sel, bus.port_valid,
                           bus.done0, bus.done1, bus.timeout_err}, e.bits);
        end
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.req0       = 1'b0;
        bus.req1       = 1'b0;
        bus.port_ready = 1'b0;

        step(1, 0, 0, 0, E_IDLE,      "reset_a");
        step(1, 0, 0, 0, E_IDLE,      "reset_b");
        // req0 alone, ready on the terminal-count cycle wins over timeout
        step(0, 1, 0, 0, E_IDLE,      "r0_req");
        step(0, 1, 0, 0, E_OWN0,      "r0_gnt");
        step(0, 1, 0, 0, E_OWN0,      "r0_hold1");
        step(0, 1, 0, 0, E_OWN0,      "r0_hold2");
        step(0, 0, 0, 1, E_OWN0 | D0, "r0_done_drop_ignored");
        step(0, 0, 0, 0, E_IDLE,      "r0_back_idle");
        step(0, 0, 0, 1, E_IDLE,      "idle_ready_no_pulse");
        step(0, 0, 0, 0, E_IDLE,      "idle_stays");
        // both from reset: requester 0 first, then handoff without bubble
        step(1, 0, 0, 0, E_IDLE,      "reset2");
        step(0, 1, 1, 0, E_IDLE,      "both_req");
        step(0, 1, 1, 1, E_OWN0 | D0, "both_own0_done");
        step(0, 0, 1, 0, E_OWN1,      "handoff_own1");
        step(0, 1, 1, 1, E_OWN1 | D1, "own1_done");
        // continuous alternation
        step(0, 1, 1, 1, E_OWN0 | D0, "alt_0a");
        step(0, 1, 1, 1, E_OWN1 | D1, "alt_1a");
        step(0, 1, 1, 1, E_OWN0 | D0, "alt_0b");
        step(0, 1, 1, 1, E_OWN1 | D1, "alt_1b");
        step(0, 0, 0, 1, E_OWN0 | D0, "alt_last");
        step(0, 0, 0, 0, E_IDLE,      "alt_idle");
        // tie from IDLE after requester 0 was served goes to requester 1
        step(0, 1, 1, 0, E_IDLE,      "rr_tie_req");
        step(0, 1, 1, 0, E_OWN1,      "rr_own1_c0");
        step(0, 1, 1, 0, E_OWN1,      "to1_c1");
        step(0, 1, 1, 0, E_OWN1,      "to1_c2");
        step(0, 1, 1, 0, E_OWN1 | TO, "to1_timeout_to_other");
        step(0, 0, 1, 1, E_OWN0 | D0, "after_to_own0");
        // timeout with the owner still requesting and no other request
        step(0, 0, 1, 0, E_OWN1,      "to2_c0");
        step(0, 0, 1, 0, E_OWN1,      "to2_c1");
        step(0, 0, 1, 0, E_OWN1,      "to2_c2");
        step(0, 0, 1, 0, E_OWN1 | TO, "to2_timeout");
        step(0, 0, 1, 0, E_IDLE,      "to2_forced_idle");
        step(0, 0, 1, 0, E_OWN1,      "rereq_own1");
        // asynchronous reset mid-grant, then tie goes to requester 0
        step(1, 1, 1, 0, E_IDLE,      "async_rst_own1");
        step(0, 1, 1, 0, E_IDLE,      "post_rst_idle");
        step(0, 1, 1, 0, E_OWN0,      "post_rst_own0");
        step(0, 0, 0, 1, E_OWN0 | D0, "post_rst_done0");
        step(0, 0, 0, 0, E_IDLE,      "final_idle");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_arbiter_2.md
# port_arbiter_2

Two-requester round-robin arbiter that sequences one shared downstream port (memory or register-file write port) between requester 0 (instruction side) and requester 1 (data side). It drives the select line of the 2:1 datapath multiplexer in front of the shared port, qualifies the port with a valid strobe, holds the grant until the port completes, and releases it on completion or on a hold timeout. It sits between the two requesting units and the shared port's input mux.

## Interface
Parameters:
- TIMEOUT, 16, max cycles a grant is held waiting for port_ready before forced release (legal range 2..255)
- TW, 8, width of the hold counter (must satisfy 2^TW > TIMEOUT)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req0  input  1  requester 0 wants the port; held high until done0 or timeout_err
- req1  input  1  requester 1 wants the port; same rule
- port_ready  input  1  shared port completes the current transfer this cycle
- sel  output  1  mux Ctrl: 0 selects requester 0 bus (A), 1 selects requester 1 bus (B)
- port_valid  output  1  a granted transfer is presented to the port
- gnt0  output  1  requester 0 owns the port
- gnt1  output  1  requester 1 owns the port
- done0  output  1  one-cycle pulse, requester 0 transfer completed
- done1  output  1  one-cycle pulse, requester 1 transfer completed
- timeout_err  output  1  one-cycle pulse, current grant released by timeout

## Operation
- States: IDLE, OWN0, OWN1. Registered last-served pointer `last` (0 or 1).
- Reset: state IDLE, last=1 (requester 0 wins first tie), hold counter 0; all outputs 0, sel=0.
- IDLE: req0 & req1 -> OWN(!last); only reqk -> OWNk; none -> IDLE.
- OWNk: gntk=1, sel=k, port_valid=1, counter increments each cycle.
- OWNk with port_ready=1: donek=1 (combinational, same cycle), last<=k, counter<=0; next state: other requester requesting -> OWN(other); else reqk still high -> OWNk (new transfer); else IDLE.
- OWNk with port_ready=0 and counter==TIMEOUT-1: timeout_err=1, donek=0, last<=k, counter<=0; next state per the same rule as completion, but reqk is ignored for this decision (owner must drop and re-request).
- port_ready while IDLE: ignored, no pulse.
- Requester dropping reqk mid-grant: ignored; grant holds until completion or timeout (no abort).
- gnt0 and gnt1 never both 1; sel changes only on state transitions.
- Counter saturates at TIMEOUT-1; never wraps.

## Timing
- Grant latency from IDLE: req asserted in cycle t -> gnt/port_valid high in cycle t+1.
- Back-to-back handoff: completion in cycle t -> other requester owns in cycle t+1, no idle bubble.
- done/timeout_err valid in the completion cycle, combinational from state and port_ready.
- sel, gnt0, gnt1, port_valid are decoded directly from the state register (glitch-free, registered).
- Asynchronous rst mid-grant: outputs drop to reset values immediately, no done pulse.
- Maximum grant duration: TIMEOUT cycles.

## Structure
- Shared include/package: state encodings (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and default TIMEOUT constant, reused by the CPU's other sequencers.
- One sub-module: hold_timer (TW-bit counter with clear, enable, and terminal-count output at TIMEOUT-1).
- The 2:1 mux stays outside; the top level wires sel to its Ctrl input.

## Test plan
- Reset then req0=1 alone, port_ready after 3 cycles -> gnt0 at cycle 1, sel=0, done0 pulse at cycle 4, return to IDLE.
- req0=req1=1 together from reset -> OWN0 first; on port_ready, OWN1 next cycle with sel=1, no bubble; then OWN0 if req0 re-asserted.
- Both held high continuously, port_ready every cycle -> grants alternate 0,1,0,1; done0/done1 alternate.
- TIMEOUT=4, req1=1, port_ready never -> timeout_err pulses at the 4th owned cycle, no done1, arbiter goes to IDLE / other requester.
- rst asserted during OWN1 -> gnt1, port_valid, sel drop to 0 asynchronously; after release, req0&req1 -> OWN0 first.
- port_ready pulsed while IDLE -> no done pulse, state stays IDLE.
